// File: rtl/cam_match_ram_pkg.sv
// rtl/cam_match_ram_pkg.sv - shared helpers and priority-mode constants for the CAM match RAM
package cam_match_ram_pkg;

  localparam string PRI_HIGH = "HIGH";
  localparam string PRI_LOW  = "LOW";

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // An encoder needs at least one output bit even for a single input.
  function automatic int enc_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/cam_match_ram_pri_enc_tree.sv
// rtl/cam_match_ram_pri_enc_tree.sv - recursive binary-tree priority encoder
module pri_enc_tree
  import cam_match_ram_pkg::*;
#(
  parameter int    WIDTH        = 32,
  parameter string LSB_PRIORITY = "HIGH",
  localparam int   EW           = enc_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [EW-1:0]    encoded,
  output logic [WIDTH-1:0] unencoded
);

  localparam bit LOWEST_WINS = (LSB_PRIORITY != PRI_LOW);

  generate
    if (WIDTH == 1) begin : g_leaf1
      assign valid     = data[0];
      assign encoded   = '0;
      assign unencoded = data;
    end else if (WIDTH == 2) begin : g_leaf2
      assign valid = data[0] | data[1];
      if (LOWEST_WINS) begin : g_lo
        assign encoded   = data[1] & ~data[0];
        assign unencoded = {data[1] & ~data[0], data[0]};
      end else begin : g_hi
        assign encoded   = data[1];
        assign unencoded = {data[1], data[0] & ~data[1]};
      end
    end else begin : g_split
      // Lower half is the largest power of two below WIDTH; the upper half
      // takes the remainder, which is equivalent to zero-padding the inputs.
      localparam int H    = (1 << clog2(WIDTH)) / 2;
      localparam int U    = WIDTH - H;
      localparam int SUBW = EW - 1;
      localparam int UEW  = enc_width(U);

      logic           lo_valid, hi_valid, sel_hi;
      logic [SUBW-1:0] lo_enc;
      logic [UEW-1:0]  hi_enc;
      logic [H-1:0]    lo_un;
      logic [U-1:0]    hi_un;

      pri_enc_tree #(.WIDTH(H), .LSB_PRIORITY(LSB_PRIORITY)) u_lo (
        .data      (data[H-1:0]),
        .valid     (lo_valid),
        .encoded   (lo_enc),
        .unencoded (lo_un)
      );

      pri_enc_tree #(.WIDTH(U), .LSB_PRIORITY(LSB_PRIORITY)) u_hi (
        .data      (data[WIDTH-1:H]),
        .valid     (hi_valid),
        .encoded   (hi_enc),
        .unencoded (hi_un)
      );

      assign sel_hi    = LOWEST_WINS ? (hi_valid & ~lo_valid) : hi_valid;
      assign valid     = lo_valid | hi_valid;
      assign encoded   = sel_hi ? {1'b1, SUBW'(hi_enc)} : {1'b0, lo_enc};
      assign unencoded = sel_hi ? {hi_un, {H{1'b0}}} : {{U{1'b0}}, lo_un};
    end
  endgenerate

endmodule

// File: rtl/cam_match_ram.sv
// rtl/cam_match_ram.sv - dual-port match RAM with port-A priority encoder for the BRAM CAM
module cam_match_ram
  import cam_match_ram_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 9,
  parameter string LSB_PRIORITY = "HIGH",
  localparam int   ENC_WIDTH    = enc_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic [DATA_WIDTH-1:0] a_dout,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  match_valid,
  output logic [ENC_WIDTH-1:0]  match_addr,
  output logic [DATA_WIDTH-1:0] match_onehot
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Port B is written last so it wins a same-address double write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (a_we) mem[a_addr] <= a_din;
      if (b_we) mem[b_addr] <= b_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)       a_dout <= '0;
    else if (a_we) a_dout <= a_din;
    else           a_dout <= mem[a_addr];
  end

  always_ff @(posedge clk) begin
    if (rst)       b_dout <= '0;
    else if (b_we) b_dout <= b_din;
    else           b_dout <= mem[b_addr];
  end

  pri_enc_tree #(.WIDTH(DATA_WIDTH), .LSB_PRIORITY(LSB_PRIORITY)) u_enc (
    .data      (a_dout),
    .valid     (match_valid),
    .encoded   (match_addr),
    .unencoded (match_onehot)
  );

endmodule

// File: tb/tb_cam_match_ram.sv
// tb/tb_cam_match_ram.sv - self-checking bench for cam_match_ram
module tb_cam_match_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_we, b_we;
  logic [8:0]  a_addr, b_addr;
  logic [31:0] a_din, b_din, a_dout, b_dout, match_onehot;
  logic        match_valid;
  logic [4:0]  match_addr;

  logic       s5_a_we, s5_b_we;
  logic [2:0] s5_a_addr, s5_b_addr;
  logic [4:0] s5_a_din, s5_b_din, s5_a_dout, s5_b_dout, s5_onehot;
  logic       s5_valid;
  logic [2:0] s5_addr;

  logic       t1_a_we, t1_b_we;
  logic [0:0] t1_a_addr, t1_b_addr;
  logic [7:0] t1_a_din, t1_b_din, t1_a_dout, t1_b_dout, t1_onehot;
  logic       t1_valid;
  logic [2:0] t1_addr;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] model_mem [512];
  logic [31:0] exp_a, exp_b;

  always #5 clk = ~clk;

  cam_match_ram dut (
    .clk(clk), .rst(rst),
    .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
    .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
    .match_valid(match_valid), .match_addr(match_addr), .match_onehot(match_onehot)
  );

  cam_match_ram #(.DATA_WIDTH(5), .ADDR_WIDTH(3), .LSB_PRIORITY("LOW")) dut5 (
    .clk(clk), .rst(rst),
    .a_we(s5_a_we), .a_addr(s5_a_addr), .a_din(s5_a_din), .a_dout(s5_a_dout),
    .b_we(s5_b_we), .b_addr(s5_b_addr), .b_din(s5_b_din), .b_dout(s5_b_dout),
    .match_valid(s5_valid), .match_addr(s5_addr), .match_onehot(s5_onehot)
  );

  cam_match_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(1)) dut1 (
    .clk(clk), .rst(rst),
    .a_we(t1_a_we), .a_addr(t1_a_addr), .a_din(t1_a_din), .a_dout(t1_a_dout),
    .b_we(t1_b_we), .b_addr(t1_b_addr), .b_din(t1_b_din), .b_dout(t1_b_dout),
    .match_valid(t1_valid), .match_addr(t1_addr), .match_onehot(t1_onehot)
  );

  // Winning bit index of a word, or -1 when no bit is set.
  function automatic int ref_win(input logic [31:0] w, input int width, input bit lowest);
    int idx = -1;
    for (int i = 0; i < width; i++)
      if (w[i] && (!lowest || idx < 0)) idx = i;
    return idx;
  endfunction

  // One clock on the main DUT; the model predicts both douts and updates memory.
  task automatic step(input logic r, input logic awe, input logic [8:0] aa, input logic [31:0] ad,
                      input logic bwe, input logic [8:0] ba, input logic [31:0] bd);
    rst = r; a_we = awe; a_addr = aa; a_din = ad;
    b_we = bwe; b_addr = ba; b_din = bd;
    @(posedge clk);
    if (r) begin
      exp_a = 32'd0;
      exp_b = 32'd0;
    end else begin
      exp_a = awe ? ad : model_mem[aa];
      exp_b = bwe ? bd : model_mem[ba];
      if (awe) model_mem[aa] = ad;
      if (bwe) model_mem[ba] = bd;
    end
    #1;
  endtask

  task automatic check_main(input string tag);
    int idx;
    logic [4:0]  ea;
    logic [31:0] eo;
    idx = ref_win(exp_a, 32, 1'b1);
    ea = (idx < 0) ? 5'd0 : 5'(idx);
    eo = (idx < 0) ? 32'd0 : (32'd1 << idx);
    tests_run++;
    if (a_dout !== exp_a || b_dout !== exp_b) begin
      tests_failed++;
      $display("FAIL %s dout: a=%h b=%h required a=%h b=%h", tag, a_dout, b_dout, exp_a, exp_b);
    end
    tests_run++;
    if (match_valid !== (idx >= 0) || match_addr !== ea || match_onehot !== eo) begin
      tests_failed++;
      $display("FAIL %s match: v=%b addr=%0d oh=%h required v=%b addr=%0d oh=%h",
               tag, match_valid, match_addr, match_onehot, idx >= 0, ea, eo);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 9'd3, 32'hFFFF_FFFF, 1'b0, 9'd0, 32'd0);
    step(1'b1, 1'b1, 9'd3, 32'hFFFF_FFFF, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'd0 || b_dout !== 32'd0 || match_valid !== 1'b0 ||
        match_addr !== 5'd0 || match_onehot !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state: a=%h b=%h v=%b addr=%0d oh=%h required all zero",
               a_dout, b_dout, match_valid, match_addr, match_onehot);
    end
    step(1'b0, 1'b0, 9'd3, 32'd0, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_write_suppressed: a_dout=%h required 0", a_dout);
    end
  endtask

  task automatic test_port_b_write();
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'd5, 32'h0000_0120);
    tests_run++;
    if (b_dout !== 32'h120) begin
      tests_failed++;
      $display("FAIL b_write_first: b_dout=%h required 120", b_dout);
    end
    step(1'b0, 1'b0, 9'd5, 32'd0, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'h120 || match_valid !== 1'b1 || match_addr !== 5'd5 || match_onehot !== 32'h20) begin
      tests_failed++;
      $display("FAIL b_readback: a=%h v=%b addr=%0d oh=%h required 120 1 5 20",
               a_dout, match_valid, match_addr, match_onehot);
    end
  endtask

  task automatic test_priority();
    logic [31:0] words [3];
    logic [4:0]  addrs [3];
    logic        valids [3];
    words = '{32'h8000_0001, 32'h8000_0000, 32'h0};
    addrs = '{5'd0, 5'd31, 5'd0};
    valids = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'(20 + i), words[i]);
      step(1'b0, 1'b0, 9'(20 + i), 32'd0, 1'b0, 9'd0, 32'd0);
      tests_run++;
      if (match_valid !== valids[i] || match_addr !== addrs[i]) begin
        tests_failed++;
        $display("FAIL priority_%0d: v=%b addr=%0d required v=%b addr=%0d",
                 i, match_valid, match_addr, valids[i], addrs[i]);
      end
    end
    for (int i = 0; i < 32; i++) begin
      logic [31:0] w;
      w = $urandom() & ($urandom() << $urandom_range(0, 31));
      step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'(40 + i), w);
      step(1'b0, 1'b0, 9'(40 + i), 32'd0, 1'b0, 9'd0, 32'd0);
      check_main("priority_rand");
    end
  endtask

  task automatic test_collision();
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'd7, 32'hA);
    step(1'b0, 1'b0, 9'd7, 32'd0, 1'b1, 9'd7, 32'hB);
    tests_run++;
    if (a_dout !== 32'hA || b_dout !== 32'hB) begin
      tests_failed++;
      $display("FAIL collision_rbw: a=%h b=%h required a=a b=b", a_dout, b_dout);
    end
    step(1'b0, 1'b0, 9'd7, 32'd0, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'hB) begin
      tests_failed++;
      $display("FAIL collision_after: a=%h required b", a_dout);
    end
    step(1'b0, 1'b1, 9'd7, 32'h1, 1'b1, 9'd7, 32'h2);
    tests_run++;
    if (a_dout !== 32'h1 || b_dout !== 32'h2) begin
      tests_failed++;
      $display("FAIL dual_write_dout: a=%h b=%h required a=1 b=2", a_dout, b_dout);
    end
    step(1'b0, 1'b0, 9'd7, 32'd0, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'h2) begin
      tests_failed++;
      $display("FAIL dual_write_b_wins: a=%h required 2", a_dout);
    end
  endtask

  task automatic test_rmw();
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'd9, 32'h6);
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 9'd9, 32'd0);
    tests_run++;
    if (b_dout !== 32'h6) begin
      tests_failed++;
      $display("FAIL rmw_read: b_dout=%h required 6", b_dout);
    end
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 9'd9, (b_dout & ~32'h2) | 32'h8);
    step(1'b0, 1'b0, 9'd9, 32'd0, 1'b0, 9'd0, 32'd0);
    tests_run++;
    if (a_dout !== 32'hC || match_addr !== 5'd2) begin
      tests_failed++;
      $display("FAIL rmw_result: a=%h addr=%0d required c 2", a_dout, match_addr);
    end
  endtask

  task automatic test_sweep();
    int bad = 0;
    for (int i = 0; i < 512; i++)
      step(1'b0, 1'b1, 9'(i), (32'(i) * 32'h9E37_79B1) ^ 32'(i), 1'b0, 9'd0, 32'd0);
    for (int i = 0; i < 512; i++) begin
      step(1'b0, 1'b0, 9'(i), 32'd0, 1'b0, 9'(511 - i), 32'd0);
      if (a_dout !== ((32'(i) * 32'h9E37_79B1) ^ 32'(i)) ||
          b_dout !== ((32'(511 - i) * 32'h9E37_79B1) ^ 32'(511 - i))) begin
        if (bad < 4) $display("FAIL sweep addr %0d: a=%h b=%h", i, a_dout, b_dout);
        bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL sweep_alias: %0d bad reads required 0", bad);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic [31:0] ad, bd;
      case ($urandom_range(0, 3))
        0: ad = 32'd0;
        1: ad = 32'd1 << $urandom_range(0, 31);
        2: ad = $urandom();
        default: ad = $urandom() & $urandom() & $urandom();
      endcase
      bd = $urandom() & $urandom();
      step($urandom_range(0, 39) == 0, 1'($urandom()), 9'($urandom_range(0, 15)), ad,
           1'($urandom()), 9'($urandom_range(0, 15)), bd);
      check_main("random");
    end
  endtask

  task automatic test_small_width();
    for (int v = 0; v < 32; v++) begin
      int idx;
      s5_a_we = 1'b0; s5_b_we = 1'b1; s5_b_addr = 3'(v); s5_b_din = 5'(v);
      @(posedge clk); #1;
      s5_b_we = 1'b0; s5_a_addr = 3'(v);
      @(posedge clk); #1;
      idx = ref_win(32'(v), 5, 1'b0);
      tests_run++;
      if (s5_a_dout !== 5'(v) || s5_valid !== (idx >= 0) ||
          s5_addr !== ((idx < 0) ? 3'd0 : 3'(idx)) ||
          s5_onehot !== ((idx < 0) ? 5'd0 : 5'(32'd1 << idx))) begin
        tests_failed++;
        $display("FAIL w5_low word %h: dout=%h v=%b addr=%0d oh=%b required idx %0d",
                 v, s5_a_dout, s5_valid, s5_addr, s5_onehot, idx);
      end
      if (v == 22) begin
        tests_run++;
        if (s5_addr !== 3'd4 || s5_onehot !== 5'b10000) begin
          tests_failed++;
          $display("FAIL w5_10110: addr=%0d oh=%b required 4 10000", s5_addr, s5_onehot);
        end
      end
    end
  endtask

  task automatic test_addr1();
    t1_a_we = 1'b1; t1_a_addr = 1'b0; t1_a_din = 8'h11;
    t1_b_we = 1'b1; t1_b_addr = 1'b1; t1_b_din = 8'h22;
    @(posedge clk); #1;
    t1_a_we = 1'b0; t1_b_we = 1'b0; t1_a_addr = 1'b1; t1_b_addr = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (t1_a_dout !== 8'h22 || t1_b_dout !== 8'h11 || t1_addr !== 3'd1 || t1_onehot !== 8'h02) begin
      tests_failed++;
      $display("FAIL aw1_read: a=%h b=%h addr=%0d oh=%h required 22 11 1 02",
               t1_a_dout, t1_b_dout, t1_addr, t1_onehot);
    end
    t1_a_we = 1'b1; t1_a_addr = 1'b0; t1_a_din = 8'h80;
    @(posedge clk); #1;
    t1_a_we = 1'b0; t1_a_addr = 1'b1; t1_b_addr = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (t1_a_dout !== 8'h22 || t1_b_dout !== 8'h80) begin
      tests_failed++;
      $display("FAIL aw1_independent: a=%h b=%h required 22 80", t1_a_dout, t1_b_dout);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) model_mem[i] = 32'd0;
    s5_a_we = 1'b0; s5_b_we = 1'b0; s5_a_addr = '0; s5_b_addr = '0; s5_a_din = '0; s5_b_din = '0;
    t1_a_we = 1'b0; t1_b_we = 1'b0; t1_a_addr = '0; t1_b_addr = '0; t1_a_din = '0; t1_b_din = '0;
    test_reset();
    test_port_b_write();
    test_priority();
    test_collision();
    test_rmw();
    test_sweep();
    test_random();
    step(1'b0, 1'b0, 9'd0, 32'd0, 1'b0, 9'd0, 32'd0);
    test_small_width();
    test_addr1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
